// File: rtl/mp_pkg.sv
// Shared types and constants for the UART receive front-end.
package mp_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam int MP_BYTE_W = 8;

endpackage

// File: rtl/mp_sync_fifo.sv
// Purpose: single-clock FIFO with push/pop, empty flag, occupancy count and drop indication.
// Latency: a push is visible on head_dat/empty/count the cycle after it is accepted.
// Backpressure: a push while full is dropped (drop=1) unless a pop happens in the same cycle.
module mp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     empty,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign drop     = push && full && !do_pop;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mp_uart_rx_fifo.sv
// Purpose: 8N1 UART receiver (2-flop synchroniser, LSB first) feeding a small byte FIFO.
// Latency: byte appears on rd_valid_o/rd_data_o one cycle after the stop-bit sample.
// Backpressure: consumer drains via rd_valid_o/rd_ready_i; bytes arriving to a full FIFO are dropped with overrun_o.
module mp_uart_rx_fifo
    import mp_pkg::*;
#(
    parameter int  CLKS_PER_BIT = 16,
    parameter int  FIFO_DEPTH   = 4,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx_i,
    input  logic                 rd_ready_i,
    output logic                 rd_valid_o,
    output logic [MP_BYTE_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]     fifo_count_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam logic [CLK_W-1:0] HALF_BIT = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CLK_W-1:0] LAST_CLK = CLK_W'(CLKS_PER_BIT - 1);

    uart_state_t          state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CLK_W-1:0]     clk_cnt;
    logic [2:0]           bit_cnt;
    logic [MP_BYTE_W-1:0] shreg;
    logic                 bit_end;
    logic                 push;
    logic                 fifo_empty;
    logic                 fifo_drop;

    assign bit_end = (clk_cnt == LAST_CLK);
    assign push    = ena && (state == STOP) && bit_end && rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rx_s        <= rx_meta;
            frame_err_o <= 1'b0;
            overrun_o   <= fifo_drop;
            if (!ena) begin
                state   <= IDLE;
                clk_cnt <= '0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state <= START;
                        end
                    end
                    START: begin
                        // Mid start bit: a high line here was only a glitch.
                        if (clk_cnt == HALF_BIT) begin
                            clk_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= rx_s ? IDLE : DATA;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shreg   <= {rx_s, shreg[MP_BYTE_W-1:1]};
                            clk_cnt <= '0;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            clk_cnt     <= '0;
                            state       <= IDLE;
                            frame_err_o <= !rx_s;
                        end else begin
                            clk_cnt <= clk_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    mp_sync_fifo #(
        .WIDTH (MP_BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (shreg),
        .pop      (rd_ready_i),
        .head_dat (rd_data_o),
        .empty    (fifo_empty),
        .drop     (fifo_drop),
        .count    (fifo_count_o)
    );

    assign rd_valid_o = !fifo_empty;

endmodule

// File: tb/tb_mp_uart_rx_fifo.sv
// Bench for mp_uart_rx_fifo: serial stimulus with a byte scoreboard and error-pulse counters.
module tb_mp_uart_rx_fifo;

    localparam int CPB = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       rx_i = 1'b0;
    logic       rd_ready_i = 1'b0;
    logic       rd_valid_o;
    logic [7:0] rd_data_o;
    logic [2:0] fifo_count_o;
    logic       frame_err_o;
    logic       overrun_o;

    int         n_pass = 0;
    int         n_total = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] exp_q[$];

    mp_uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .rx_i         (rx_i),
        .rd_ready_i   (rd_ready_i),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .fifo_count_o (fifo_count_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    // Every high cycle counts, so a stretched pulse shows up as an extra event.
    always @(negedge clk) begin
        if (frame_err_o) fe_cnt++;
        if (overrun_o) ov_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_b, input bit keep);
        if (keep) exp_q.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_b);
        rx_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        logic [7:0] want;
        int         guard;
        guard = 0;
        while (rd_valid_o && guard < DEPTH + 2) begin
            guard++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s_extra: got byte %h, want no byte", tag, rd_data_o);
            end else begin
                want = exp_q.pop_front();
                if (rd_data_o !== want)
                    $display("FAIL %s_data: got %h, want %h", tag, rd_data_o, want);
                else
                    n_pass++;
            end
            rd_ready_i = 1'b1;
            @(negedge clk);
            rd_ready_i = 1'b0;
        end
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_missing: got %0d bytes left undelivered, want 0", tag, exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_i  = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({rd_valid_o, rd_data_o, fifo_count_o, frame_err_o, overrun_o} !== 13'd0)
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d fe=%b ov=%b, want all 0",
                     rd_valid_o, rd_data_o, fifo_count_o, frame_err_o, overrun_o);
        else n_pass++;
        rx_i  = 1'b1;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        n_total++;
        if (fifo_count_o !== 3'd0 || fe_cnt != 0)
            $display("FAIL reset_no_frame: got count=%0d fe=%0d, want 0/0", fifo_count_o, fe_cnt);
        else n_pass++;
    endtask

    task automatic test_single();
        send_byte(8'hA5, 1'b1, 1'b1);
        n_total++;
        if (rd_valid_o !== 1'b1 || fifo_count_o !== 3'd1)
            $display("FAIL single_valid: got v=%b c=%0d, want 1/1", rd_valid_o, fifo_count_o);
        else n_pass++;
        drain("single");
        n_total++;
        if (rd_valid_o !== 1'b0 || fifo_count_o !== 3'd0 || rd_data_o !== 8'h00)
            $display("FAIL single_empty: got v=%b c=%0d d=%h, want 0/0/00",
                     rd_valid_o, fifo_count_o, rd_data_o);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int fe0;
        fe0  = fe_cnt;
        rx_i = 1'b0;
        repeat (6) @(negedge clk);
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        n_total++;
        if (fifo_count_o !== 3'd0 || fe_cnt != fe0)
            $display("FAIL glitch_ignored: got count=%0d fe=%0d, want 0/0", fifo_count_o, fe_cnt - fe0);
        else n_pass++;
        send_byte(8'h81, 1'b1, 1'b1);
        drain("after_glitch");
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (32) @(negedge clk);
        n_total++;
        if (fe_cnt - fe0 != 1)
            $display("FAIL frame_err_pulses: got %0d, want 1", fe_cnt - fe0);
        else n_pass++;
        n_total++;
        if (fifo_count_o !== 3'd0 || rd_valid_o !== 1'b0)
            $display("FAIL frame_err_discard: got count=%0d v=%b, want 0/0", fifo_count_o, rd_valid_o);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int ov0;
        int fe0;
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, b <= DEPTH);
        n_total++;
        if (fifo_count_o !== 3'd4)
            $display("FAIL overrun_count: got %0d, want 4", fifo_count_o);
        else n_pass++;
        n_total++;
        if (ov_cnt - ov0 != 1 || fe_cnt != fe0)
            $display("FAIL overrun_pulses: got ov=%0d fe=%0d, want 1/0", ov_cnt - ov0, fe_cnt - fe0);
        else n_pass++;
        drain("overrun");
    endtask

    task automatic test_abort(input bit use_reset);
        int ov0;
        int fe0;
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        repeat (CPB / 2) @(negedge clk);
        if (use_reset) rst_n = 1'b0;
        else ena = 1'b0;
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (32) @(negedge clk);
        n_total++;
        if (fifo_count_o !== 3'd0)
            $display("FAIL abort_partial_%0d: got count=%0d, want 0", use_reset, fifo_count_o);
        else n_pass++;
        send_byte(8'h5A, 1'b1, 1'b1);
        n_total++;
        if (fifo_count_o !== 3'd1 || ov_cnt != ov0 || fe_cnt != fe0)
            $display("FAIL abort_resume_%0d: got count=%0d ov=%0d fe=%0d, want 1/0/0",
                     use_reset, fifo_count_o, ov_cnt - ov0, fe_cnt - fe0);
        else n_pass++;
        drain("abort");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
